// File: rtl/axi_arbiter_pkg.sv
// Shared types and defaults for the round-robin AXI-stream arbiter.
// Optional packet cap: define AXI_ARB_PKT_LIMIT_EN.
package axi_arbiter_pkg;

  localparam int DATA_SIZE       = 32;
  localparam int ID_SIZE         = 8;
  localparam int NUM_CHANNELS    = 4;
  localparam int CHANNELS_W      = $clog2(NUM_CHANNELS);
  localparam int MAX_PACKET_SIZE = 4;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  typedef logic [CHANNELS_W-1:0] Channel;

  typedef struct packed {
    logic [DATA_SIZE-1:0] data;
    logic [ID_SIZE-1:0]   id;
    Channel               idx_channel;
    logic                 last;
  } axi_data_t;

endpackage

// File: rtl/axi_rr_sel.sv
// Rotating-priority search: first requester at or after ptr_i,
// wrapping to the lowest requester below it.
module axi_rr_sel
  import axi_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  logic [W-1:0] hi_idx;
  logic [W-1:0] lo_idx;
  logic         hi_hit;

  // Descending scan so the lowest matching index wins.
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    hi_hit = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if (req_i[j]) begin
        lo_idx = W'(j);
        if (W'(j) >= ptr_i) begin
          hi_idx = W'(j);
          hi_hit = 1'b1;
        end
      end
    end
  end

  assign idx_o = hi_hit ? hi_idx : lo_idx;
  assign any_o = |req_i;

endmodule

// File: rtl/axi_rr_arbiter.sv
// Packet-locked round-robin merge of NUM_CHANNELS streams into one.
// Define AXI_ARB_PKT_LIMIT_EN to cut packets at MAX_PACKET_SIZE beats.
module axi_rr_arbiter #(
  parameter int DATA_SIZE       = axi_arbiter_pkg::DATA_SIZE,
  parameter int ID_SIZE         = axi_arbiter_pkg::ID_SIZE,
  parameter int NUM_CHANNELS    = axi_arbiter_pkg::NUM_CHANNELS,
  parameter int MAX_PACKET_SIZE = axi_arbiter_pkg::MAX_PACKET_SIZE,
  localparam int CHANNELS_W     = $clog2(NUM_CHANNELS)
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [NUM_CHANNELS-1:0]      s_valid,
  output logic [NUM_CHANNELS-1:0]      s_ready,
  input  logic [NUM_CHANNELS*DATA_SIZE-1:0] s_data,
  input  logic [NUM_CHANNELS*ID_SIZE-1:0]   s_id,
  input  logic [NUM_CHANNELS-1:0]      s_last,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DATA_SIZE-1:0]         m_data,
  output logic [ID_SIZE-1:0]           m_id,
  output logic                         m_last,
  output logic [CHANNELS_W-1:0]        m_channel
);

  import axi_arbiter_pkg::*;

  localparam int CW = CHANNELS_W;

  logic [0:0]           state_q, state_d;
  logic [CW-1:0]        ptr_q, ptr_d;
  logic [CW-1:0]        grant_q, grant_d;
  logic                 m_valid_q, m_valid_d;
  logic [DATA_SIZE-1:0] m_data_q, m_data_d;
  logic [ID_SIZE-1:0]   m_id_q, m_id_d;
  logic                 m_last_q, m_last_d;
  logic [CW-1:0]        m_chan_q, m_chan_d;

  logic [CW-1:0]        win;
  logic                 any_req;
  logic                 g_valid;
  logic                 g_last;
  logic [DATA_SIZE-1:0] g_data;
  logic [ID_SIZE-1:0]   g_id;
  logic                 busy;
  logic                 out_free;
  logic                 acc;
  logic                 cap_hit;
  logic                 eff_last;

  axi_rr_sel #(
    .N (NUM_CHANNELS),
    .W (CW)
  ) u_sel (
    .req_i (s_valid),
    .ptr_i (ptr_q),
    .idx_o (win),
    .any_o (any_req)
  );

  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    g_id    = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (grant_q == CW'(i)) begin
        g_valid = s_valid[i];
        g_last  = s_last[i];
        g_data  = s_data[i*DATA_SIZE +: DATA_SIZE];
        g_id    = s_id[i*ID_SIZE +: ID_SIZE];
      end
    end
  end

  assign busy     = (state_q == ST_BUSY);
  assign out_free = m_ready || !m_valid_q;
  assign acc      = busy && g_valid && out_free;
  assign eff_last = g_last || cap_hit;

  always_comb begin
    s_ready = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (aresetn && busy && grant_q == CW'(i)) begin
        s_ready[i] = out_free;
      end
    end
  end

`ifdef AXI_ARB_PKT_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_PACKET_SIZE + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign cap_hit = (cnt_q == CNT_W'(MAX_PACKET_SIZE - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (acc) begin
      cnt_d = eff_last ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign cap_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant_d = win;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (acc && eff_last) begin
          state_d = ST_IDLE;
          if (grant_q == CW'(NUM_CHANNELS - 1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = grant_q + CW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_id_d    = m_id_q;
    m_last_d  = m_last_q;
    m_chan_d  = m_chan_q;
    if (acc) begin
      m_valid_d = 1'b1;
      m_data_d  = g_data;
      m_id_d    = g_id;
      m_last_d  = eff_last;
      m_chan_d  = grant_q;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_id_q    <= '0;
      m_last_q  <= 1'b0;
      m_chan_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_id_q    <= m_id_d;
      m_last_q  <= m_last_d;
      m_chan_q  <= m_chan_d;
    end
  end

  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_id      = m_id_q;
  assign m_last    = m_last_q;
  assign m_channel = m_chan_q;

endmodule
